// File: rtl/branch_predictor.sv
// Fetch-stage branch predictor: instruction classifier, 2-bit PHT, circular RAS.
// Optional resolved/mispredict counters are built with BRANCH_PREDICTOR_STATS_EN.
module branch_predictor #(
  parameter int PC_WIDTH    = 32,
  parameter int PHT_BITS    = 6,
  parameter int RAS_DEPTH   = 4,
  parameter int LINK_OFFSET = 4
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                lk_valid,
  input  logic [PC_WIDTH-1:0] lk_pc,
  input  logic [5:0]          lk_opcode,
  input  logic [4:0]          lk_rs,
  input  logic [4:0]          lk_rt,
  input  logic [5:0]          lk_funct,
  input  logic                upd_valid,
  input  logic [PC_WIDTH-1:0] upd_pc,
  input  logic                upd_taken,
  input  logic                upd_pred,
  output logic                pred_valid,
  output logic                pred_cf,
  output logic                pred_cond,
  output logic                pred_taken,
  output logic                pred_ret,
  output logic [PC_WIDTH-1:0] pred_target,
  output logic [31:0]         stat_cond,
  output logic [31:0]         stat_miss
);

  localparam int PHT_N = 1 << PHT_BITS;
  localparam int RP_W  = $clog2(RAS_DEPTH);
  localparam int OC_W  = RP_W + 1;

  localparam logic [5:0] OP_SPECIAL = 6'b000000;
  localparam logic [5:0] OP_REGIMM  = 6'b000001;
  localparam logic [5:0] OP_J       = 6'b000010;
  localparam logic [5:0] OP_JAL     = 6'b000011;
  localparam logic [5:0] OP_BEQ     = 6'b000100;
  localparam logic [5:0] OP_BNE     = 6'b000101;
  localparam logic [5:0] OP_BLEZ    = 6'b000110;
  localparam logic [5:0] OP_BGTZ    = 6'b000111;
  localparam logic [5:0] FN_JR      = 6'b001000;
  localparam logic [5:0] FN_JALR    = 6'b001001;

  logic is_j;
  logic is_jal;
  logic is_jr;
  logic is_jalr;
  logic is_bcc;
  logic is_rimm;

  always_comb begin
    is_j    = lk_opcode == OP_J;
    is_jal  = lk_opcode == OP_JAL;
    is_jr   = (lk_opcode == OP_SPECIAL) && (lk_funct == FN_JR);
    is_jalr = (lk_opcode == OP_SPECIAL) && (lk_funct == FN_JALR);
    is_bcc  = (lk_opcode == OP_BEQ)  || (lk_opcode == OP_BNE) ||
              (lk_opcode == OP_BLEZ) || (lk_opcode == OP_BGTZ);
    // BLTZ/BGEZ/BLTZAL/BGEZAL only: rt = x000y with x = link
    is_rimm = (lk_opcode == OP_REGIMM) &&
              (lk_rt[3:1] == 3'b000);
  end

  logic dec_unc;
  logic dec_cond;
  logic dec_push;
  logic dec_ret;

  always_comb begin
    dec_unc  = 1'b0;
    dec_cond = 1'b0;
    dec_push = 1'b0;
    dec_ret  = 1'b0;
    unique case (1'b1)
      is_j: dec_unc = 1'b1;
      is_jal: begin
        dec_unc  = 1'b1;
        dec_push = 1'b1;
      end
      is_jr: begin
        dec_unc = 1'b1;
        dec_ret = 1'b1;
      end
      is_jalr: begin
        dec_unc  = 1'b1;
        dec_push = 1'b1;
        dec_ret  = 1'b1;
      end
      is_bcc: dec_cond = 1'b1;
      is_rimm: begin
        dec_cond = 1'b1;
        dec_push = lk_rt[4];
      end
      default: ;
    endcase
  end

  logic push;
  logic pop;

  assign push = lk_valid && dec_push;
  assign pop  = lk_valid && dec_ret && (lk_rs == 5'd31);

  logic [1:0]          pht [PHT_N];
  logic [PHT_BITS-1:0] lk_idx;
  logic [PHT_BITS-1:0] upd_idx;
  logic [1:0]          upd_cur;
  logic [1:0]          upd_nxt;

  assign lk_idx  = lk_pc[PHT_BITS+1:2];
  assign upd_idx = upd_pc[PHT_BITS+1:2];
  assign upd_cur = pht[upd_idx];

  always_comb begin
    upd_nxt = upd_cur;
    if (upd_taken && upd_cur != 2'b11) begin
      upd_nxt = upd_cur + 2'b01;
    end else if (!upd_taken && upd_cur != 2'b00) begin
      upd_nxt = upd_cur - 2'b01;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < PHT_N; i++) begin
        pht[i] <= 2'b01;
      end
    end else if (upd_valid) begin
      pht[upd_idx] <= upd_nxt;
    end
  end

  logic [PC_WIDTH-1:0] ras [RAS_DEPTH];
  logic [RP_W-1:0]     ptr;
  logic [RP_W-1:0]     ptr_dn;
  logic [OC_W-1:0]     occ;
  logic [PC_WIDTH-1:0] link;
  logic [PC_WIDTH-1:0] top;
  logic                hit;

  assign ptr_dn = ptr - 1'b1;
  assign top    = ras[ptr_dn];
  assign hit    = pop && (occ != '0);
  assign link   = lk_pc + PC_WIDTH'(LINK_OFFSET);

  // ptr is the next free slot; a full push overwrites the oldest
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ptr <= '0;
      occ <= '0;
      for (int i = 0; i < RAS_DEPTH; i++) begin
        ras[i] <= '0;
      end
    end else if (hit && push) begin
      ras[ptr_dn] <= link;
    end else if (hit) begin
      ptr <= ptr_dn;
      occ <= occ - 1'b1;
    end else if (push) begin
      ras[ptr] <= link;
      ptr      <= ptr + 1'b1;
      if (occ != OC_W'(RAS_DEPTH)) begin
        occ <= occ + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pred_valid  <= 1'b0;
      pred_cf     <= 1'b0;
      pred_cond   <= 1'b0;
      pred_taken  <= 1'b0;
      pred_ret    <= 1'b0;
      pred_target <= '0;
    end else begin
      pred_valid  <= lk_valid;
      pred_cf     <= lk_valid && (dec_unc || dec_cond);
      pred_cond   <= lk_valid && dec_cond;
      pred_taken  <= lk_valid &&
                     (dec_unc || (dec_cond && pht[lk_idx][1]));
      pred_ret    <= hit;
      pred_target <= hit ? top : '0;
    end
  end

`ifdef BRANCH_PREDICTOR_STATS_EN
  logic [31:0] cond_q;
  logic [31:0] miss_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cond_q <= '0;
      miss_q <= '0;
    end else if (upd_valid) begin
      cond_q <= cond_q + 32'd1;
      if (upd_taken != upd_pred) begin
        miss_q <= miss_q + 32'd1;
      end
    end
  end

  assign stat_cond = cond_q;
  assign stat_miss = miss_q;
`else
  assign stat_cond = '0;
  assign stat_miss = '0;
`endif

  logic unused_ok;
  assign unused_ok = ^{upd_pc[PC_WIDTH-1:PHT_BITS+2],
                       upd_pc[1:0], upd_pred};

endmodule

// File: tb/tb_branch_predictor.sv
// Bench for branch_predictor: classification table, hand sequences,
// and randomized traffic against a queue/array reference model.
module tb_branch_predictor;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        lk_valid = 1'b0;
  logic [31:0] lk_pc = '0;
  logic [5:0]  lk_opcode = '0;
  logic [4:0]  lk_rs = '0;
  logic [4:0]  lk_rt = '0;
  logic [5:0]  lk_funct = '0;
  logic        upd_valid = 1'b0;
  logic [31:0] upd_pc = '0;
  logic        upd_taken = 1'b0;
  logic        upd_pred = 1'b0;
  logic        pred_valid;
  logic        pred_cf;
  logic        pred_cond;
  logic        pred_taken;
  logic        pred_ret;
  logic [31:0] pred_target;
  logic [31:0] stat_cond;
  logic [31:0] stat_miss;

  branch_predictor dut (
    .clk(clk), .reset_n(reset_n),
    .lk_valid(lk_valid), .lk_pc(lk_pc),
    .lk_opcode(lk_opcode), .lk_rs(lk_rs),
    .lk_rt(lk_rt), .lk_funct(lk_funct),
    .upd_valid(upd_valid), .upd_pc(upd_pc),
    .upd_taken(upd_taken), .upd_pred(upd_pred),
    .pred_valid(pred_valid), .pred_cf(pred_cf),
    .pred_cond(pred_cond), .pred_taken(pred_taken),
    .pred_ret(pred_ret), .pred_target(pred_target),
    .stat_cond(stat_cond), .stat_miss(stat_miss)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // reference model: counter values 0..3, RAS as a bounded queue
  int          mpht [64];
  logic [31:0] mras [$];
  int unsigned mcond;
  int unsigned mmiss;

  task automatic check(input string name,
                       input logic [63:0] act,
                       input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 64; i++) mpht[i] = 1;
    mras.delete();
    mcond = 0;
    mmiss = 0;
  endtask

  task automatic clear_inputs();
    lk_valid  = 1'b0;
    lk_pc     = '0;
    lk_opcode = '0;
    lk_rs     = '0;
    lk_rt     = '0;
    lk_funct  = '0;
    upd_valid = 1'b0;
    upd_pc    = '0;
    upd_taken = 1'b0;
    upd_pred  = 1'b0;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    clear_inputs();
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic step(input logic v, input logic [31:0] pc,
                      input logic [5:0] op, input logic [4:0] rs,
                      input logic [4:0] rt, input logic [5:0] fn,
                      input logic uv, input logic [31:0] upc,
                      input logic ut, input logic up);
    bit cf, cond, tk, ret, push, pop;
    logic [31:0] tgt;
    logic [31:0] es_c, es_m;
    int uidx;
    cf = 0; cond = 0; tk = 0; ret = 0;
    push = 0; pop = 0; tgt = '0;
    if (v) begin
      case (op)
        6'h00: begin
          if (fn == 6'h08 || fn == 6'h09) begin
            cf = 1; tk = 1;
            pop = (rs == 31);
            push = (fn == 6'h09);
          end
        end
        6'h02: begin cf = 1; tk = 1; end
        6'h03: begin cf = 1; tk = 1; push = 1; end
        6'h01: begin
          if (rt == 0 || rt == 1 || rt == 16 || rt == 17) begin
            cond = 1;
            push = (rt >= 16);
          end
        end
        6'h04, 6'h05, 6'h06, 6'h07: cond = 1;
        default: ;
      endcase
      if (cond) begin
        cf = 1;
        tk = (mpht[(pc >> 2) % 64] >= 2);
      end
    end
    if (pop && mras.size() > 0) begin
      ret = 1;
      tgt = mras.pop_back();
    end
    if (push) begin
      mras.push_back(pc + 32'd4);
      if (mras.size() > 4) void'(mras.pop_front());
    end
    lk_valid = v; lk_pc = pc; lk_opcode = op;
    lk_rs = rs; lk_rt = rt; lk_funct = fn;
    upd_valid = uv; upd_pc = upc;
    upd_taken = ut; upd_pred = up;
    @(posedge clk);
    #1;
    if (uv) begin
      uidx = (upc >> 2) % 64;
      if (ut && mpht[uidx] < 3) mpht[uidx]++;
      if (!ut && mpht[uidx] > 0) mpht[uidx]--;
      mcond++;
      if (ut != up) mmiss++;
    end
`ifdef BRANCH_PREDICTOR_STATS_EN
    es_c = mcond;
    es_m = mmiss;
`else
    es_c = 0;
    es_m = 0;
`endif
    check("m.valid", pred_valid, v);
    check("m.cf", pred_cf, cf);
    check("m.cond", pred_cond, cond);
    check("m.taken", pred_taken, tk);
    check("m.ret", pred_ret, ret);
    check("m.target", pred_target, tgt);
    check("m.stat_cond", stat_cond, es_c);
    check("m.stat_miss", stat_miss, es_m);
    clear_inputs();
  endtask

  task automatic lk(input logic [31:0] pc, input logic [5:0] op,
                    input logic [4:0] rs, input logic [4:0] rt,
                    input logic [5:0] fn);
    step(1'b1, pc, op, rs, rt, fn, 1'b0, '0, 1'b0, 1'b0);
  endtask

  task automatic upd(input logic [31:0] pc, input logic t,
                     input logic p);
    step(1'b0, '0, '0, '0, '0, '0, 1'b1, pc, t, p);
  endtask

  typedef struct {
    logic [5:0] op;
    logic [4:0] rs;
    logic [4:0] rt;
    logic [5:0] fn;
    logic       cf;
    logic       cond;
    logic       tk;
  } vec_t;

  vec_t tbl [15];

  initial begin
    tbl[0]  = '{6'h02, 5'd0, 5'd0,  6'h00, 1, 0, 1};
    tbl[1]  = '{6'h03, 5'd0, 5'd0,  6'h00, 1, 0, 1};
    tbl[2]  = '{6'h00, 5'd5, 5'd0,  6'h08, 1, 0, 1};
    tbl[3]  = '{6'h00, 5'd5, 5'd0,  6'h09, 1, 0, 1};
    tbl[4]  = '{6'h04, 5'd1, 5'd2,  6'h00, 1, 1, 0};
    tbl[5]  = '{6'h05, 5'd1, 5'd2,  6'h00, 1, 1, 0};
    tbl[6]  = '{6'h06, 5'd1, 5'd0,  6'h00, 1, 1, 0};
    tbl[7]  = '{6'h07, 5'd1, 5'd0,  6'h00, 1, 1, 0};
    tbl[8]  = '{6'h01, 5'd3, 5'd0,  6'h00, 1, 1, 0};
    tbl[9]  = '{6'h01, 5'd3, 5'd1,  6'h00, 1, 1, 0};
    tbl[10] = '{6'h01, 5'd3, 5'd16, 6'h00, 1, 1, 0};
    tbl[11] = '{6'h01, 5'd3, 5'd17, 6'h00, 1, 1, 0};
    tbl[12] = '{6'h01, 5'd3, 5'd2,  6'h00, 0, 0, 0};
    tbl[13] = '{6'h00, 5'd3, 5'd4,  6'h20, 0, 0, 0};
    tbl[14] = '{6'h23, 5'd3, 5'd4,  6'h08, 0, 0, 0};

    do_reset();
    check("reset.valid", pred_valid, 0);
    check("reset.cf", pred_cf, 0);
    check("reset.taken", pred_taken, 0);
    check("reset.ret", pred_ret, 0);
    check("reset.target", pred_target, 0);
    check("reset.stat", stat_cond, 0);

    for (int i = 0; i < 15; i++) begin
      lk(32'h1000 + 32'(i * 4), tbl[i].op, tbl[i].rs,
         tbl[i].rt, tbl[i].fn);
      check($sformatf("tbl%0d.cf", i), pred_cf, tbl[i].cf);
      check($sformatf("tbl%0d.cond", i), pred_cond, tbl[i].cond);
      check($sformatf("tbl%0d.taken", i), pred_taken, tbl[i].tk);
    end

    // weakly not-taken at reset, two taken updates flip it
    do_reset();
    lk(32'h100, 6'h04, 5'd1, 5'd2, 6'h00);
    check("beq.valid", pred_valid, 1);
    check("beq.cond", pred_cond, 1);
    check("beq.taken0", pred_taken, 0);
    upd(32'h100, 1, 0);
    upd(32'h100, 1, 0);
    lk(32'h100, 6'h04, 5'd1, 5'd2, 6'h00);
    check("beq.taken1", pred_taken, 1);

    // saturation at both ends and same-cycle read-before-write
    repeat (4) upd(32'h40, 1, 0);
    upd(32'h40, 0, 1);
    lk(32'h40, 6'h05, 5'd1, 5'd2, 6'h00);
    check("sat.hi", pred_taken, 1);
    repeat (4) upd(32'h40, 0, 1);
    lk(32'h40, 6'h05, 5'd1, 5'd2, 6'h00);
    check("sat.lo", pred_taken, 0);
    upd(32'h40, 1, 0);
    lk(32'h40, 6'h05, 5'd1, 5'd2, 6'h00);
    check("sat.lo_stays", pred_taken, 0);
    step(1, 32'h40, 6'h05, 5'd1, 5'd2, 6'h00, 1, 32'h40, 1, 0);
    check("same.pre", pred_taken, 0);
    lk(32'h40, 6'h05, 5'd1, 5'd2, 6'h00);
    check("same.post", pred_taken, 1);

    // call/return and empty pop
    do_reset();
    lk(32'h200, 6'h03, 5'd0, 5'd0, 6'h00);
    lk(32'h260, 6'h00, 5'd31, 5'd0, 6'h08);
    check("ret.hit", pred_ret, 1);
    check("ret.target", pred_target, 32'h204);
    lk(32'h264, 6'h00, 5'd31, 5'd0, 6'h08);
    check("ret.empty", pred_ret, 0);
    check("ret.empty_tgt", pred_target, 0);

    // overflow drops the oldest
    do_reset();
    for (int i = 1; i <= 5; i++) lk(32'(i * 16), 6'h03, 0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      lk(32'h800, 6'h00, 5'd31, 5'd0, 6'h08);
      check($sformatf("ovf%0d.ret", i), pred_ret, 1);
      check($sformatf("ovf%0d.tgt", i), pred_target,
            32'h54 - 32'(i * 16));
    end
    lk(32'h800, 6'h00, 5'd31, 5'd0, 6'h08);
    check("ovf.empty", pred_ret, 0);

    // JALR $31 swaps top; link wraps modulo 2^32
    do_reset();
    lk(32'h300, 6'h03, 0, 0, 0);
    lk(32'h400, 6'h00, 5'd31, 5'd0, 6'h09);
    check("jalr.tgt", pred_target, 32'h304);
    lk(32'h500, 6'h00, 5'd31, 5'd0, 6'h08);
    check("jalr.link", pred_target, 32'h404);
    lk(32'h504, 6'h00, 5'd31, 5'd0, 6'h08);
    check("jalr.net", pred_ret, 0);
    lk(32'hFFFF_FFFC, 6'h03, 0, 0, 0);
    lk(32'h10, 6'h00, 5'd31, 5'd0, 6'h08);
    check("wrap.tgt", pred_target, 0);
    check("wrap.ret", pred_ret, 1);

    // idle lookup leaves RAS untouched
    step(0, 32'h600, 6'h03, 0, 0, 0, 0, '0, 0, 0);
    check("idle.valid", pred_valid, 0);
    check("idle.cf", pred_cf, 0);
    lk(32'h700, 6'h00, 5'd31, 5'd0, 6'h08);
    check("idle.noPush", pred_ret, 0);

    do_reset();
    upd(32'h80, 1, 1);
    upd(32'h84, 0, 1);
    upd(32'h88, 1, 1);
`ifdef BRANCH_PREDICTOR_STATS_EN
    check("stat.cond", stat_cond, 3);
    check("stat.miss", stat_miss, 1);
`else
    check("stat.cond_off", stat_cond, 0);
    check("stat.miss_off", stat_miss, 0);
`endif

    // async reset between edges
    upd(32'h40, 1, 1);
    upd(32'h40, 1, 0);
    lk(32'h900, 6'h03, 0, 0, 0);
    #2 reset_n = 1'b0;
    #1;
    check("areset.valid", pred_valid, 0);
    check("areset.cf", pred_cf, 0);
    check("areset.stat_cond", stat_cond, 0);
    check("areset.stat_miss", stat_miss, 0);
    do_reset();
    lk(32'h40, 6'h04, 0, 0, 0);
    check("areset.pht", pred_taken, 0);
    lk(32'h44, 6'h00, 5'd31, 5'd0, 6'h08);
    check("areset.ras", pred_ret, 0);

    // randomized traffic checked against the model every cycle
    for (int n = 0; n < 1500; n++) begin
      logic [31:0] pc, upc;
      logic [5:0] op, fn;
      logic [4:0] rs, rt;
      int k;
      pc = 32'h1000 + 32'($urandom_range(0, 15) * 4);
      upc = 32'h1000 + 32'($urandom_range(0, 15) * 4);
      rs = 5'($urandom);
      rt = 5'($urandom);
      fn = 6'($urandom);
      k = $urandom_range(0, 9);
      case (k)
        0: op = 6'h02;
        1: op = 6'h03;
        2: begin op = 6'h00; fn = 6'h08; rs = 5'd31; end
        3: begin op = 6'h00; fn = 6'h09; rs = 5'd31; end
        4: op = 6'h04;
        5: op = 6'h05;
        6: begin
          op = 6'h01;
          if ($urandom_range(0, 3) != 0) rt = {rt[4], 3'b000, rt[0]};
        end
        7: begin op = 6'h00; fn = 6'h20; end
        8: op = 6'h07;
        default: op = 6'($urandom);
      endcase
      if (n % 300 == 299) begin
        do_reset();
      end
      step($urandom_range(0, 4) != 0, pc, op, rs, rt, fn,
           $urandom_range(0, 1) == 1, upc,
           1'($urandom), 1'($urandom));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
